// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
// MEM_ALIGN_CHECK_EN enables the alignment check helper's use in mem_stage.
package mem_stage_pkg;

  localparam logic MEM_IDLE = 1'b0;
  localparam logic MEM_BUSY = 1'b1;

  function automatic logic misaligned(
    input logic       load,
    input logic [3:0] we,
    input logic [1:0] a
  );
    logic word;
    logic half;
    word = (we == 4'hF);
    half = (we == 4'h3) || (we == 4'hC);
    return (load && (a != 2'b00))
        || (word && (a != 2'b00))
        || (half && a[0]);
  endfunction

endpackage

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: bus loads/stores and mem->wb registers.
// Optional MEM_ALIGN_CHECK_EN traps misaligned accesses instead of issuing them.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] alu_data_mem,
  input  logic [DATA_WIDTH-1:0] reg_t_data_mem,
  input  logic [3:0]            mem_we_mem,
  input  logic                  reg_d_we_mem,
  input  logic [ADDR_WIDTH-1:0] reg_d_addr_mem,
  input  logic                  reg_d_data_sel_mem,
  output logic                  stall_mem,
  output logic                  dbus_req,
  output logic [DATA_WIDTH-1:0] dbus_addr,
  output logic [3:0]            dbus_we,
  output logic [DATA_WIDTH-1:0] dbus_wdata,
  input  logic                  dbus_ack,
  input  logic [DATA_WIDTH-1:0] dbus_rdata,
  output logic                  reg_d_we_wb,
  output logic [ADDR_WIDTH-1:0] reg_d_addr_wb,
  output logic [DATA_WIDTH-1:0] reg_d_data_wb,
  output logic                  misalign_mem
);

  logic state;
  logic load;
  logic store;
  logic access;
  logic mis;
  logic go;

  assign load   = reg_d_data_sel_mem & reg_d_we_mem;
  assign store  = |mem_we_mem;
  assign access = load | store;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = access
             & misaligned(load, mem_we_mem, alu_data_mem[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign go = access & ~mis;

  always_comb begin
    stall_mem = 1'b0;
    if (state == MEM_IDLE) begin
      stall_mem = go;
    end else begin
      stall_mem = ~dbus_ack;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= MEM_IDLE;
      dbus_req      <= 1'b0;
      dbus_addr     <= '0;
      dbus_we       <= 4'h0;
      dbus_wdata    <= '0;
      reg_d_we_wb   <= 1'b0;
      reg_d_addr_wb <= '0;
      reg_d_data_wb <= '0;
      misalign_mem  <= 1'b0;
    end else begin
      misalign_mem <= 1'b0;
      case (state)
        MEM_IDLE: begin
          if (go) begin
            dbus_req    <= 1'b1;
            dbus_addr   <= alu_data_mem;
            dbus_we     <= mem_we_mem;
            dbus_wdata  <= reg_t_data_mem;
            reg_d_we_wb <= 1'b0;
            state       <= MEM_BUSY;
          end else if (mis) begin
            reg_d_we_wb  <= 1'b0;
            misalign_mem <= 1'b1;
          end else begin
            reg_d_we_wb   <= reg_d_we_mem;
            reg_d_addr_wb <= reg_d_addr_mem;
            reg_d_data_wb <= alu_data_mem;
          end
        end
        MEM_BUSY: begin
          // Bus outputs hold until the ack edge; retire there.
          if (dbus_ack) begin
            dbus_req      <= 1'b0;
            dbus_we       <= 4'h0;
            reg_d_we_wb   <= reg_d_we_mem;
            reg_d_addr_wb <= reg_d_addr_mem;
            reg_d_data_wb <= load ? dbus_rdata : alu_data_mem;
            state         <= MEM_IDLE;
          end
        end
        default: state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Expected values are hand-computed per scenario.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alu_data_mem;
  logic [31:0] reg_t_data_mem;
  logic [3:0]  mem_we_mem;
  logic        reg_d_we_mem;
  logic [4:0]  reg_d_addr_mem;
  logic        reg_d_data_sel_mem;
  logic        stall_mem;
  logic        dbus_req;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_we;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        reg_d_we_wb;
  logic [4:0]  reg_d_addr_wb;
  logic [31:0] reg_d_data_wb;
  logic        misalign_mem;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .alu_data_mem       (alu_data_mem),
    .reg_t_data_mem     (reg_t_data_mem),
    .mem_we_mem         (mem_we_mem),
    .reg_d_we_mem       (reg_d_we_mem),
    .reg_d_addr_mem     (reg_d_addr_mem),
    .reg_d_data_sel_mem (reg_d_data_sel_mem),
    .stall_mem          (stall_mem),
    .dbus_req           (dbus_req),
    .dbus_addr          (dbus_addr),
    .dbus_we            (dbus_we),
    .dbus_wdata         (dbus_wdata),
    .dbus_ack           (dbus_ack),
    .dbus_rdata         (dbus_rdata),
    .reg_d_we_wb        (reg_d_we_wb),
    .reg_d_addr_wb      (reg_d_addr_wb),
    .reg_d_data_wb      (reg_d_data_wb),
    .misalign_mem       (misalign_mem)
  );

  task automatic nop();
    alu_data_mem       = 32'h0;
    reg_t_data_mem     = 32'h0;
    mem_we_mem         = 4'h0;
    reg_d_we_mem       = 1'b0;
    reg_d_addr_mem     = 5'd0;
    reg_d_data_sel_mem = 1'b0;
  endtask

  task automatic load_in(input logic [31:0] a, input logic [4:0] d);
    alu_data_mem       = a;
    reg_t_data_mem     = 32'h0;
    mem_we_mem         = 4'h0;
    reg_d_we_mem       = 1'b1;
    reg_d_addr_mem     = d;
    reg_d_data_sel_mem = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dbus_ack = 1'b0;
    dbus_rdata = 32'h0;
    nop();
    step();
    step();
    checks++;
    if (dbus_req !== 1'b0 || dbus_we !== 4'h0) begin
      fails++;
      $display("FAIL reset_bus: req=%b we=%h want 0/0", dbus_req, dbus_we);
    end
    checks++;
    if (dbus_addr !== 32'h0 || dbus_wdata !== 32'h0) begin
      fails++;
      $display("FAIL reset_bus_data: addr=%h wdata=%h want 0/0",
               dbus_addr, dbus_wdata);
    end
    checks++;
    if (reg_d_we_wb !== 1'b0 || reg_d_addr_wb !== 5'd0
        || reg_d_data_wb !== 32'h0) begin
      fails++;
      $display("FAIL reset_wb: we=%b addr=%h data=%h want 0/0/0",
               reg_d_we_wb, reg_d_addr_wb, reg_d_data_wb);
    end
    checks++;
    if (misalign_mem !== 1'b0 || stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL reset_misc: mis=%b stall=%b want 0/0",
               misalign_mem, stall_mem);
    end
    rst = 1'b0;
  endtask

  task automatic test_alu_op();
    alu_data_mem   = 32'h1234;
    reg_d_we_mem   = 1'b1;
    reg_d_addr_mem = 5'd5;
    #1;
    checks++;
    if (stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL alu_stall: got %b want 0", stall_mem);
    end
    step();
    nop();
    #1;
    checks++;
    if (reg_d_we_wb !== 1'b1 || reg_d_addr_wb !== 5'd5
        || reg_d_data_wb !== 32'h1234) begin
      fails++;
      $display("FAIL alu_wb: we=%b addr=%0d data=%h want 1/5/1234",
               reg_d_we_wb, reg_d_addr_wb, reg_d_data_wb);
    end
    checks++;
    if (dbus_req !== 1'b0) begin
      fails++;
      $display("FAIL alu_req: got %b want 0", dbus_req);
    end
    step();
  endtask

  task automatic test_load();
    int stalls;
    stalls = 0;
    load_in(32'h100, 5'd7);
    for (int c = 0; c < 5; c++) begin
      dbus_ack   = (c == 4);
      dbus_rdata = (c == 4) ? 32'hDEADBEEF : 32'h0;
      #1;
      if (stall_mem === 1'b1) stalls++;
      if (c == 1) begin
        checks++;
        if (dbus_req !== 1'b1 || dbus_addr !== 32'h100
            || dbus_we !== 4'h0) begin
          fails++;
          $display("FAIL load_bus: req=%b addr=%h we=%h want 1/100/0",
                   dbus_req, dbus_addr, dbus_we);
        end
      end
      step();
    end
    dbus_ack = 1'b0;
    nop();
    #1;
    checks++;
    if (stalls != 4) begin
      fails++;
      $display("FAIL load_stall_cycles: got %0d want 4", stalls);
    end
    checks++;
    if (reg_d_we_wb !== 1'b1 || reg_d_addr_wb !== 5'd7
        || reg_d_data_wb !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL load_wb: we=%b addr=%0d data=%h want 1/7/deadbeef",
               reg_d_we_wb, reg_d_addr_wb, reg_d_data_wb);
    end
    checks++;
    if (dbus_req !== 1'b0) begin
      fails++;
      $display("FAIL load_req_drop: got %b want 0", dbus_req);
    end
    step();
  endtask

  task automatic test_store();
    alu_data_mem   = 32'h103;
    reg_t_data_mem = 32'hAB;
    mem_we_mem     = 4'h1;
    #1;
    checks++;
    if (stall_mem !== 1'b1 || dbus_req !== 1'b0) begin
      fails++;
      $display("FAIL store_present: stall=%b req=%b want 1/0",
               stall_mem, dbus_req);
    end
    step();
    checks++;
    if (dbus_req !== 1'b1 || dbus_we !== 4'h1 || dbus_addr !== 32'h103
        || dbus_wdata !== 32'hAB) begin
      fails++;
      $display("FAIL store_bus: req=%b we=%h addr=%h wdata=%h want 1/1/103/ab",
               dbus_req, dbus_we, dbus_addr, dbus_wdata);
    end
    dbus_ack = 1'b1;
    #1;
    checks++;
    if (stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL store_ack_stall: got %b want 0", stall_mem);
    end
    step();
    dbus_ack = 1'b0;
    nop();
    #1;
    checks++;
    if (dbus_req !== 1'b0 || dbus_we !== 4'h0 || reg_d_we_wb !== 1'b0) begin
      fails++;
      $display("FAIL store_done: req=%b we=%h wb_we=%b want 0/0/0",
               dbus_req, dbus_we, reg_d_we_wb);
    end
    step();
  endtask

  task automatic test_stray_ack_reset();
    nop();
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h55;
    #1;
    checks++;
    if (stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL stray_stall: got %b want 0", stall_mem);
    end
    step();
    checks++;
    if (dbus_req !== 1'b0 || reg_d_we_wb !== 1'b0) begin
      fails++;
      $display("FAIL stray_ack: req=%b wb_we=%b want 0/0",
               dbus_req, reg_d_we_wb);
    end
    dbus_ack = 1'b0;
    load_in(32'h200, 5'd9);
    step();
    checks++;
    if (dbus_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_busy_req: got %b want 1", dbus_req);
    end
    rst = 1'b1;
    nop();
    step();
    rst = 1'b0;
    checks++;
    if (dbus_req !== 1'b0 || reg_d_we_wb !== 1'b0
        || reg_d_data_wb !== 32'h0) begin
      fails++;
      $display("FAIL rst_busy: req=%b wb_we=%b data=%h want 0/0/0",
               dbus_req, reg_d_we_wb, reg_d_data_wb);
    end
    dbus_ack = 1'b1;
    #1;
    checks++;
    if (stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL late_ack_stall: got %b want 0", stall_mem);
    end
    step();
    dbus_ack = 1'b0;
    checks++;
    if (dbus_req !== 1'b0 || reg_d_we_wb !== 1'b0
        || reg_d_data_wb !== 32'h0) begin
      fails++;
      $display("FAIL late_ack: req=%b wb_we=%b data=%h want 0/0/0",
               dbus_req, reg_d_we_wb, reg_d_data_wb);
    end
  endtask

  task automatic test_back_to_back();
    load_in(32'h10, 5'd2);
    step();
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h11;
    step();
    dbus_ack = 1'b0;
    load_in(32'h20, 5'd3);
    #1;
    checks++;
    if (dbus_req !== 1'b0 || reg_d_data_wb !== 32'h11
        || reg_d_addr_wb !== 5'd2) begin
      fails++;
      $display("FAIL b2b_first: req=%b data=%h addr=%0d want 0/11/2",
               dbus_req, reg_d_data_wb, reg_d_addr_wb);
    end
    checks++;
    if (stall_mem !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second_stall: got %b want 1", stall_mem);
    end
    step();
    checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h20) begin
      fails++;
      $display("FAIL b2b_second_req: req=%b addr=%h want 1/20",
               dbus_req, dbus_addr);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'h22;
    step();
    dbus_ack = 1'b0;
    nop();
    #1;
    checks++;
    if (reg_d_we_wb !== 1'b1 || reg_d_addr_wb !== 5'd3
        || reg_d_data_wb !== 32'h22) begin
      fails++;
      $display("FAIL b2b_second_wb: we=%b addr=%0d data=%h want 1/3/22",
               reg_d_we_wb, reg_d_addr_wb, reg_d_data_wb);
    end
    step();
  endtask

  task automatic test_misalign();
    load_in(32'h102, 5'd4);
    #1;
`ifdef MEM_ALIGN_CHECK_EN
    checks++;
    if (stall_mem !== 1'b0) begin
      fails++;
      $display("FAIL mis_stall: got %b want 0", stall_mem);
    end
    step();
    nop();
    #1;
    checks++;
    if (misalign_mem !== 1'b1 || dbus_req !== 1'b0
        || reg_d_we_wb !== 1'b0) begin
      fails++;
      $display("FAIL mis_pulse: mis=%b req=%b wb_we=%b want 1/0/0",
               misalign_mem, dbus_req, reg_d_we_wb);
    end
    step();
    checks++;
    if (misalign_mem !== 1'b0) begin
      fails++;
      $display("FAIL mis_one_cycle: got %b want 0", misalign_mem);
    end
`else
    checks++;
    if (stall_mem !== 1'b1) begin
      fails++;
      $display("FAIL unal_stall: got %b want 1", stall_mem);
    end
    step();
    checks++;
    if (dbus_req !== 1'b1 || dbus_addr !== 32'h102) begin
      fails++;
      $display("FAIL unal_req: req=%b addr=%h want 1/102",
               dbus_req, dbus_addr);
    end
    dbus_ack   = 1'b1;
    dbus_rdata = 32'hCAFE;
    step();
    dbus_ack = 1'b0;
    nop();
    #1;
    checks++;
    if (reg_d_data_wb !== 32'hCAFE || reg_d_we_wb !== 1'b1
        || misalign_mem !== 1'b0) begin
      fails++;
      $display("FAIL unal_wb: data=%h we=%b mis=%b want cafe/1/0",
               reg_d_data_wb, reg_d_we_wb, misalign_mem);
    end
    step();
`endif
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_load();
    test_store();
    test_stray_ack_reset();
    test_back_to_back();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
